// File: rtl/phase_ctrl.sv
// Instruction phase sequencer: steps one instruction at a time through fetch,
// decode, execute, memory and writeback, and counts retired instructions.
module phase_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             step,
    input  logic             halt_req,
    input  logic             stall,
    output logic             en_ft,
    output logic             en_dc,
    output logic             en_ex,
    output logic             en_ma,
    output logic             en_wb,
    output logic [2:0]       phase,
    output logic             busy,
    output logic [CNT_W-1:0] retired
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_FT   = 3'd1;
    localparam logic [2:0] S_DC   = 3'd2;
    localparam logic [2:0] S_EX   = 3'd3;
    localparam logic [2:0] S_MA   = 3'd4;
    localparam logic [2:0] S_WB   = 3'd5;

    logic [2:0]       state_q, state_d;
    logic             halt_pend_q, halt_pend_d;
    logic             step_mode_q, step_mode_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             stalled;

    // Only the memory-facing phases can be held off by stall.
    assign stalled = stall && (state_q == S_FT || state_q == S_MA);

    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE:  state_d = ((run || step) && !halt_pend_q && !halt_req) ? S_FT : S_IDLE;
            S_FT:    state_d = stalled ? S_FT : S_DC;
            S_DC:    state_d = S_EX;
            S_EX:    state_d = S_MA;
            S_MA:    state_d = stalled ? S_MA : S_WB;
            S_WB:    state_d = (halt_pend_q || halt_req || step_mode_q || !run) ? S_IDLE : S_FT;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        halt_pend_d = halt_pend_q;
        step_mode_d = step_mode_q;
        if (state_d == S_IDLE) begin
            halt_pend_d = 1'b0;
            step_mode_d = 1'b0;
        end else if (state_q == S_IDLE) begin
            // A step with run low makes this a single-instruction excursion.
            step_mode_d = step && !run;
        end else begin
            halt_pend_d = halt_pend_q || halt_req;
        end
    end

    assign retired_d = en_wb ? retired_q + CNT_W'(1) : retired_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            halt_pend_q <= 1'b0;
            step_mode_q <= 1'b0;
            retired_q   <= '0;
        end else begin
            state_q     <= state_d;
            halt_pend_q <= halt_pend_d;
            step_mode_q <= step_mode_d;
            retired_q   <= retired_d;
        end
    end

    assign en_ft   = (state_q == S_FT) && !stalled;
    assign en_dc   = (state_q == S_DC);
    assign en_ex   = (state_q == S_EX);
    assign en_ma   = (state_q == S_MA) && !stalled;
    assign en_wb   = (state_q == S_WB);
    assign phase   = state_q;
    assign busy    = (state_q != S_IDLE);
    assign retired = retired_q;

endmodule

// File: tb/tb_phase_ctrl.sv
// Directed bench for phase_ctrl: stimulus pushes per-cycle expectations into a
// queue, a monitor pops and compares them just before each rising edge.
module tb_phase_ctrl;

    localparam logic [2:0] P_IDLE = 3'd0;
    localparam logic [2:0] P_FT   = 3'd1;
    localparam logic [2:0] P_DC   = 3'd2;
    localparam logic [2:0] P_EX   = 3'd3;
    localparam logic [2:0] P_MA   = 3'd4;
    localparam logic [2:0] P_WB   = 3'd5;

    typedef struct packed {
        logic [2:0]  ph;
        logic [4:0]  en;
        logic        busy;
        logic [15:0] ret;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic run = 1'b0, step = 1'b0, halt_req = 1'b0, stall = 1'b0;
    logic en_ft, en_dc, en_ex, en_ma, en_wb, busy;
    logic [2:0]  phase;
    logic [15:0] retired;
    logic s_ft, s_dc, s_ex, s_ma, s_wb, s_busy;
    logic [2:0] s_phase;
    logic [2:0] s_ret;

    exp_t        q[$];
    int          n_chk = 0;
    int          n_pass = 0;
    logic [15:0] exp_ret = '0;
    logic [2:0]  prev_ph = P_IDLE;

    phase_ctrl dut (
        .clk(clk), .rst_n(rst_n), .run(run), .step(step), .halt_req(halt_req), .stall(stall),
        .en_ft(en_ft), .en_dc(en_dc), .en_ex(en_ex), .en_ma(en_ma), .en_wb(en_wb),
        .phase(phase), .busy(busy), .retired(retired)
    );

    // Narrow counter copy exercises wrap-around within a short run.
    phase_ctrl #(.CNT_W(3)) u_small (
        .clk(clk), .rst_n(rst_n), .run(run), .step(step), .halt_req(halt_req), .stall(stall),
        .en_ft(s_ft), .en_dc(s_dc), .en_ex(s_ex), .en_ma(s_ma), .en_wb(s_wb),
        .phase(s_phase), .busy(s_busy), .retired(s_ret)
    );

    always #5 clk = ~clk;

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endfunction

    // Drive one cycle of inputs; ph is the state the DUT should be in this cycle.
    task automatic cyc(input logic r, input logic s, input logic h, input logic st, input logic [2:0] ph);
        exp_t e;
        @(negedge clk); #1;
        run = r; step = s; halt_req = h; stall = st;
        if (prev_ph == P_WB) exp_ret++;
        e.ph   = ph;
        e.busy = (ph != P_IDLE);
        e.en   = '0;
        if (ph != P_IDLE && !(st && (ph == P_FT || ph == P_MA))) e.en[int'(ph) - 1] = 1'b1;
        e.ret  = exp_ret;
        q.push_back(e);
        prev_ph = ph;
    endtask

    task automatic instr(input logic last_run);
        cyc(1, 0, 0, 0, P_FT);
        cyc(1, 0, 0, 0, P_DC);
        cyc(1, 0, 0, 0, P_EX);
        cyc(1, 0, 0, 0, P_MA);
        cyc(last_run, 0, 0, 0, P_WB);
    endtask

    task automatic check_zero(input string nm);
        check({nm, "_phase"}, phase, 0);
        check({nm, "_en"}, {en_wb, en_ma, en_ex, en_dc, en_ft}, 0);
        check({nm, "_busy"}, busy, 0);
        check({nm, "_retired"}, retired, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk); #4;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("phase", phase, e.ph);
                check("en", {en_wb, en_ma, en_ex, en_dc, en_ft}, e.en);
                check("busy", busy, e.busy);
                check("retired", retired, e.ret);
                check("retired_w3", s_ret, e.ret[2:0]);
            end
        end
    end

    initial begin : stim
        #2 rst_n = 1'b0;
        #1 check_zero("reset");
        @(negedge clk); #2 rst_n = 1'b1;

        // Free run, three back-to-back instructions
        cyc(1, 0, 0, 0, P_IDLE);
        for (int i = 0; i < 3; i++) instr(i == 2 ? 1'b0 : 1'b1);
        cyc(0, 0, 0, 0, P_IDLE);

        // Single step; step while busy ignored; run in WB does not continue
        cyc(0, 1, 0, 0, P_IDLE);
        cyc(0, 1, 0, 0, P_FT);
        cyc(0, 0, 0, 0, P_DC);
        cyc(0, 0, 0, 0, P_EX);
        cyc(0, 0, 0, 0, P_MA);
        cyc(1, 0, 0, 0, P_WB);
        cyc(0, 0, 0, 0, P_IDLE);

        // halt_req in IDLE blocks start only for that cycle
        cyc(1, 0, 1, 0, P_IDLE);
        cyc(1, 0, 0, 0, P_IDLE);
        // Stall honoured in FT/MA, ignored in DC/EX
        cyc(1, 0, 0, 1, P_FT);
        cyc(1, 0, 0, 0, P_FT);
        cyc(1, 0, 0, 1, P_DC);
        cyc(1, 0, 0, 1, P_EX);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 1, P_MA);
        cyc(1, 0, 0, 0, P_MA);
        cyc(1, 0, 0, 0, P_WB);
        // halt_req during EX finishes the instruction then idles
        cyc(1, 0, 0, 0, P_FT);
        cyc(1, 0, 0, 0, P_DC);
        cyc(1, 0, 1, 0, P_EX);
        cyc(1, 0, 0, 0, P_MA);
        cyc(1, 0, 0, 0, P_WB);
        cyc(1, 0, 0, 0, P_IDLE);
        // halt_req during WB idles from that same WB
        cyc(1, 0, 0, 0, P_FT);
        cyc(1, 0, 0, 0, P_DC);
        cyc(1, 0, 0, 0, P_EX);
        cyc(1, 0, 0, 0, P_MA);
        cyc(1, 0, 1, 0, P_WB);
        cyc(0, 0, 0, 0, P_IDLE);

        // Asynchronous reset in DC, run held high throughout
        cyc(1, 0, 0, 0, P_IDLE);
        cyc(1, 0, 0, 0, P_FT);
        @(negedge clk); #2;
        check("pre_rst_phase", phase, P_DC);
        check("pre_rst_retired", retired, exp_ret);
        rst_n = 1'b0;
        #1 check_zero("async_rst");
        @(negedge clk); #4 check_zero("rst_held");
        @(negedge clk); #2 rst_n = 1'b1;
        #2 check("post_release_phase", phase, P_IDLE);
        exp_ret = '0;
        prev_ph = P_IDLE;
        cyc(1, 0, 0, 0, P_FT);
        cyc(1, 0, 0, 0, P_DC);
        cyc(1, 0, 0, 0, P_EX);
        cyc(1, 0, 0, 0, P_MA);
        cyc(0, 0, 0, 0, P_WB);
        cyc(1, 0, 0, 0, P_IDLE);

        // Nine more instructions wrap the 3-bit counter
        for (int i = 0; i < 9; i++) instr(i == 8 ? 1'b0 : 1'b1);
        cyc(0, 0, 0, 0, P_IDLE);
        cyc(0, 0, 0, 0, P_IDLE);

        @(negedge clk); #6;
        check("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/phase_ctrl.md
PHASE_CTRL -- requirements
Module: phase_ctrl

Interface
REQ-001 Parameter CNT_W, default 16, width of the retired-instruction counter.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 run  input  1  level: 1 = free-running execution requested.
REQ-005 step  input  1  single-cycle pulse: execute exactly one instruction from IDLE.
REQ-006 halt_req  input  1  single-cycle pulse: stop after current instruction's WB.
REQ-007 stall  input  1  memory wait; honoured only in FT and MA phases.
REQ-008 en_ft, en_dc, en_ex, en_ma, en_wb  output  1 each  phase enables for fetch/decode/execute/memory/writeback stages.
REQ-009 phase  output  3  current state encoding: IDLE=0, FT=1, DC=2, EX=3, MA=4, WB=5.
REQ-010 busy  output  1  1 when state != IDLE.
REQ-011 retired  output  CNT_W  count of instructions completing WB.

Function
REQ-012 FSM states SHALL be IDLE, FT, DC, EX, MA, WB; encodings 6 and 7 SHALL be unreachable and SHALL transition to IDLE if entered.
REQ-013 en_X SHALL be 1 exactly when state == X and the phase is not stalled; at most one enable high per cycle.
REQ-014 Enables SHALL be combinational from registered state and stall; no other input affects them.
REQ-015 Phase stalled = stall==1 and state in {FT, MA}; stall SHALL be ignored in DC, EX, WB, IDLE.
REQ-016 A stalled phase SHALL hold state and keep its enable low; no cycle limit on stall length.
REQ-017 Unstalled FT->DC->EX->MA->WB SHALL each advance after exactly one cycle; minimum instruction latency 5 cycles.
REQ-018 IDLE->FT when (run==1 or step==1) and halt_pending==0 and halt_req==0; otherwise stay IDLE.
REQ-019 halt_pending: internal sticky flag set by halt_req in any non-IDLE state, cleared on entry to IDLE.
REQ-020 step_mode: internal flag set when leaving IDLE due to step with run==0, cleared on entry to IDLE.
REQ-021 WB->IDLE when halt_pending==1, halt_req==1, step_mode==1, or run==0; else WB->FT (back-to-back, no bubble).
REQ-022 halt_req arriving during WB SHALL take effect in that same WB (next state IDLE).
REQ-023 halt_req in IDLE SHALL be dropped (no pending state) and block start in that cycle only.
REQ-024 step while busy SHALL be ignored.
REQ-025 retired SHALL increment by 1 on every cycle en_wb==1, wrapping from 2^CNT_W-1 to 0.
REQ-026 busy SHALL equal (phase != 0).

Reset
REQ-027 rst_n low SHALL immediately force state IDLE, phase 0, busy 0, all en_* 0, retired 0, halt_pending 0, step_mode 0, regardless of clk.
REQ-028 Reset asserted mid-instruction SHALL abandon it without en_wb or counter increment.
REQ-029 After rst_n deasserts, the first state change SHALL occur no earlier than the next rising clk edge.

Verification
REQ-030 run=1 held, stall=0, 3 instructions -> enables cycle ft,dc,ex,ma,wb with no gap; retired=3 after 15 cycles.
REQ-031 step pulse with run=0 -> one FT..WB sequence, returns IDLE, retired=1, busy low 5 cycles after start.
REQ-032 run=1, stall=1 for 4 cycles during MA -> phase=4 held 5 cycles, en_ma high only in final cycle, then WB.
REQ-033 run=1, halt_req pulsed during EX -> current instruction completes WB, then IDLE; halt_req in WB -> IDLE same way.
REQ-034 retired preset to 0xFFFF via 65535 instructions (or forced), one more WB -> retired=0x0000.
REQ-035 rst_n low during DC -> outputs zero asynchronously; after release with run=1 -> FT next edge, retired starts from 0.
